// File: rtl/led_effect_scheduler.sv
// LED effect scheduler: sequences coin, die and win light effects on a
// 16-LED bank. A free-running divider produces the effect tick. One-deep
// pending latches hold die/coin requests. The priority is win > die > coin.
// The effect output is the FSM state itself, so it also serves as the debug
// view of the FSM.
module led_effect_scheduler #(
   parameter int TICK_DIV   = 2500000,
   parameter int COIN_TICKS = 4,
   parameter int DIE_TICKS  = 8
) (
   input  logic        clk_25mhz,
   input  logic        rst,
   input  logic        win,
   input  logic        die_pulse,
   input  logic        coin_pulse,
   output logic [15:0] LED,
   output logic [1:0]  effect,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_COIN = 2'd1,
      S_DIE  = 2'd2,
      S_WIN  = 2'd3
   } state_t;

   localparam logic [25:0] DIV_LAST  = 26'(TICK_DIV - 1);
   localparam logic [3:0]  COIN_LAST = 4'(COIN_TICKS);
   localparam logic [3:0]  DIE_LAST  = 4'(DIE_TICKS);

   state_t      state, state_nx;
   logic [25:0] div_cnt;
   logic        tick;
   logic [3:0]  tick_cnt, tick_cnt_nx, tick_cnt_inc;
   logic [15:0] led_nx;
   logic        die_pend, coin_pend;
   logic        die_clr, coin_clr;

   assign tick         = (div_cnt == DIV_LAST);
   assign tick_cnt_inc = tick_cnt + 4'd1;
   assign effect       = state;
   assign busy         = (state != S_IDLE);

   // Free-running tick divider; it is never realigned to effect starts.
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst)       div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 26'd1;
   end

   // State, LED, tick count and pending-latch registers.
   // A pulse in the same cycle as its clear wins, so it leaves the latch set.
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         LED       <= '0;
         tick_cnt  <= '0;
         die_pend  <= 1'b0;
         coin_pend <= 1'b0;
      end else begin
         state     <= state_nx;
         LED       <= led_nx;
         tick_cnt  <= tick_cnt_nx;
         die_pend  <= die_pulse  | (die_pend  & ~die_clr);
         coin_pend <= coin_pulse | (coin_pend & ~coin_clr);
      end
   end

   // Next-state, LED pattern and latch-clear decisions.
   always_comb begin
      state_nx    = state;
      led_nx      = LED;
      tick_cnt_nx = tick_cnt;
      die_clr     = 1'b0;
      coin_clr    = 1'b0;
      if (win) begin
         state_nx = S_WIN;
         if (state != S_WIN) led_nx = 16'hAAAA;
         else if (tick)      led_nx = {LED[0], LED[15:1]};
      end else begin
         case (state)
            S_WIN: begin
               state_nx = S_IDLE;
               led_nx   = 16'h0000;
            end
            S_IDLE, S_COIN: begin
               if (die_pend) begin
                  // Die also preempts a running coin, which is then lost.
                  state_nx    = S_DIE;
                  led_nx      = 16'hFFFF;
                  tick_cnt_nx = 4'd0;
                  die_clr     = 1'b1;
               end else if (state == S_IDLE) begin
                  if (coin_pend) begin
                     state_nx    = S_COIN;
                     led_nx      = 16'hFFFF;
                     tick_cnt_nx = 4'd0;
                     coin_clr    = 1'b1;
                  end else begin
                     led_nx = 16'h0000;
                  end
               end else if (tick) begin
                  tick_cnt_nx = tick_cnt_inc;
                  if (tick_cnt_inc == COIN_LAST) begin
                     state_nx = S_IDLE;
                     led_nx   = 16'h0000;
                  end else begin
                     led_nx = ~LED;
                  end
               end
            end
            S_DIE: begin
               if (tick) begin
                  tick_cnt_nx = tick_cnt_inc;
                  if (tick_cnt_inc == DIE_LAST) begin
                     state_nx = S_IDLE;
                     led_nx   = 16'h0000;
                  end else begin
                     led_nx = {2'b00, LED[15:2]};
                  end
               end
            end
            default: begin
               state_nx = S_IDLE;
               led_nx   = 16'h0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_effect_scheduler.sv
// Bench for led_effect_scheduler with TICK_DIV=4. The reference model tracks
// the active effect, the number of ticks elapsed in it and the two pending
// requests. It derives the LED pattern from the tick count with arithmetic.
module tb_led_effect_scheduler;

   localparam int TD = 4;
   localparam int CT = 4;
   localparam int DT = 8;

   logic        clk_25mhz = 1'b0;
   logic        rst = 1'b1;
   logic        win = 1'b0;
   logic        die_pulse = 1'b0;
   logic        coin_pulse = 1'b0;
   logic [15:0] LED;
   logic [1:0]  effect;
   logic        busy;

   int checks_total = 0;
   int checks_passed = 0;

   led_effect_scheduler #(.TICK_DIV(TD), .COIN_TICKS(CT), .DIE_TICKS(DT)) dut (
      .clk_25mhz (clk_25mhz),
      .rst       (rst),
      .win       (win),
      .die_pulse (die_pulse),
      .coin_pulse(coin_pulse),
      .LED       (LED),
      .effect    (effect),
      .busy      (busy)
   );

   // Clock generation.
   always #5 clk_25mhz = ~clk_25mhz;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else checks_passed++;
   endtask

   // Reference model: mode 0 idle, 1 coin, 2 die, 3 win; k = ticks elapsed.
   int m_mode = 0;
   int m_k = 0;
   int m_cyc = 0;
   bit m_die = 0;
   bit m_coin = 0;

   function automatic logic [15:0] model_led(input int mode, input int k);
      case (mode)
         1:       return (k % 2 == 0) ? 16'hFFFF : 16'h0000;
         2:       return 16'hFFFF >> (2 * k);
         3:       return (k % 2 == 0) ? 16'hAAAA : 16'h5555;
         default: return 16'h0000;
      endcase
   endfunction

   // Advance the model on each edge, then compare all outputs after it settles.
   always @(posedge clk_25mhz) begin
      bit tk, clr_d, clr_c;
      if (rst) begin
         m_mode = 0; m_k = 0; m_cyc = 0; m_die = 0; m_coin = 0;
      end else begin
         tk = (m_cyc % TD) == TD - 1;
         m_cyc++;
         clr_d = 0; clr_c = 0;
         if (win) begin
            if (m_mode != 3) begin m_mode = 3; m_k = 0; end
            else if (tk) m_k++;
         end else if (m_mode == 3) begin
            m_mode = 0;
         end else if (m_die && (m_mode == 0 || m_mode == 1)) begin
            m_mode = 2; m_k = 0; clr_d = 1;
         end else if (m_mode == 1 || m_mode == 2) begin
            if (tk) begin
               m_k++;
               if (m_k == ((m_mode == 1) ? CT : DT)) m_mode = 0;
            end
         end else if (m_coin) begin
            m_mode = 1; m_k = 0; clr_c = 1;
         end
         m_die  = die_pulse  || (m_die  && !clr_d);
         m_coin = coin_pulse || (m_coin && !clr_c);
      end
      #1;
      chk("model_effect", {14'd0, effect}, 16'(m_mode));
      chk("model_led", LED, model_led(m_mode, m_k));
      chk("model_busy", {15'd0, busy}, {15'd0, m_mode != 0});
   end

   task automatic wait_effect(input logic [1:0] v, input int budget, input string name);
      int n = 0;
      while (effect !== v && n < budget) begin @(negedge clk_25mhz); n++; end
      chk(name, {14'd0, effect}, {14'd0, v});
   endtask

   task automatic wait_led_change(input logic [15:0] from, input int budget);
      int n = 0;
      while (LED === from && n < budget) begin @(negedge clk_25mhz); n++; end
   endtask

   task automatic pulse_die();
      @(negedge clk_25mhz); die_pulse = 1'b1;
      @(negedge clk_25mhz); die_pulse = 1'b0;
   endtask

   task automatic pulse_coin();
      @(negedge clk_25mhz); coin_pulse = 1'b1;
      @(negedge clk_25mhz); coin_pulse = 1'b0;
   endtask

   initial begin
      // Reset state.
      repeat (3) @(negedge clk_25mhz);
      chk("reset_led", LED, 16'h0000);
      chk("reset_effect", {14'd0, effect}, 16'd0);
      chk("reset_busy", {15'd0, busy}, 16'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk_25mhz);

      // Coin: enters two edges after the pulse is driven, then returns to idle.
      pulse_coin();
      @(negedge clk_25mhz);
      chk("coin_effect", {14'd0, effect}, 16'd1);
      chk("coin_led", LED, 16'hFFFF);
      wait_led_change(16'hFFFF, 8);
      chk("coin_toggle", LED, 16'h0000);
      wait_effect(2'd0, 40, "coin_done");
      chk("coin_done_led", LED, 16'h0000);
      repeat (3) @(negedge clk_25mhz);

      // Die: first shift, then win preempts with a die pending behind it.
      pulse_die();
      wait_effect(2'd2, 4, "die_effect");
      chk("die_led0", LED, 16'hFFFF);
      wait_led_change(16'hFFFF, 8);
      chk("die_led1", LED, 16'h3FFF);
      pulse_die();
      @(negedge clk_25mhz); win = 1'b1;
      @(negedge clk_25mhz);
      chk("win_effect", {14'd0, effect}, 16'd3);
      chk("win_led", LED, 16'hAAAA);
      wait_led_change(16'hAAAA, 8);
      chk("win_rot", LED, 16'h5555);
      win = 1'b0;
      @(negedge clk_25mhz);
      chk("win_exit", {14'd0, effect}, 16'd0);
      @(negedge clk_25mhz);
      chk("die_replay", {14'd0, effect}, 16'd2);
      chk("die_replay_led", LED, 16'hFFFF);
      wait_effect(2'd0, 60, "die_replay_done");

      // Simultaneous die and coin: die runs first, then coin.
      @(negedge clk_25mhz); die_pulse = 1'b1; coin_pulse = 1'b1;
      @(negedge clk_25mhz); die_pulse = 1'b0; coin_pulse = 1'b0;
      wait_effect(2'd2, 4, "simul_die");
      wait_effect(2'd0, 60, "simul_die_done");
      @(negedge clk_25mhz);
      chk("simul_coin", {14'd0, effect}, 16'd1);
      wait_effect(2'd0, 40, "simul_coin_done");

      // Coin lost: a die two cycles after the coin preempts it for good.
      @(negedge clk_25mhz); coin_pulse = 1'b1;
      @(negedge clk_25mhz); coin_pulse = 1'b0;
      @(negedge clk_25mhz); die_pulse = 1'b1;
      @(negedge clk_25mhz); die_pulse = 1'b0;
      wait_effect(2'd2, 4, "lost_die");
      wait_effect(2'd0, 60, "lost_die_done");
      repeat (20) @(negedge clk_25mhz);
      chk("coin_not_replayed", {14'd0, effect}, 16'd0);

      // Reset during win with a die pending.
      @(negedge clk_25mhz); win = 1'b1;
      pulse_die();
      repeat (3) @(negedge clk_25mhz);
      rst = 1'b1;
      #1;
      chk("rst_async_led", LED, 16'h0000);
      chk("rst_async_effect", {14'd0, effect}, 16'd0);
      @(negedge clk_25mhz); rst = 1'b0; win = 1'b0;
      repeat (20) @(negedge clk_25mhz);
      chk("rst_no_die", {14'd0, effect}, 16'd0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_25mhz);
         die_pulse  = ($urandom_range(0, 24) == 0);
         coin_pulse = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 59) == 0) win = ~win;
         rst = ($urandom_range(0, 599) == 0);
      end
      @(negedge clk_25mhz);
      die_pulse = 1'b0; coin_pulse = 1'b0; win = 1'b0; rst = 1'b0;
      repeat (5) @(negedge clk_25mhz);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
